reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

Debug readout engine that sequentially reads every general-purpose register through the register bank's output-select lines and streams each 32-bit value out over a valid/ready interface. It is the read-side counterpart of the register bank's load path: the CPU datapath writes registers via `enable`/`d`, and this block reads them back for trace and debug dumps. It sits beside the datapath, sharing the register out-select lines, and is started by the debug controller.

## Interface
Parameters:
- `NUM_REGS`, 16: number of registers dumped; indices `0..NUM_REGS-1`.
- `IDX_W`, 4: index width, equal to `$clog2(NUM_REGS)`.

Ports:
- `clk` input 1: the single clock; everything is updated on its rising edge.
- `clr` input 1: synchronous, active-high reset; it has priority over every other input.
- `start` input 1: one-cycle request to begin a dump. It is sampled only in IDLE.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last word is accepted.
- `rd_sel` output NUM_REGS: one-hot register out-select. It is all zeros except in FETCH.
- `rd_data` input 32: the selected register's `q`, valid combinationally in the same cycle.
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: downstream accept.
- `out_data` output 32: captured register value.
- `out_index` output IDX_W: register number of `out_data`.
- `out_last` output 1: high with the word for index `NUM_REGS-1`.

## Operation
- States:
  - **IDLE**: `start` moves to FETCH and sets `idx=0`.
  - **FETCH**: drive `rd_sel = 1<<idx`. At the clock edge, capture `rd_data` into `out_data` and `idx` into `out_index`, then move to SEND.
  - **SEND**: `out_valid=1`.
    - On `out_valid && out_ready`, if `idx==NUM_REGS-1`, move to DONE.
    - Otherwise increment `idx` and move to FETCH.
    - With `out_ready` low, stay in SEND and hold every stream output stable.
  - **DONE**: `done=1` for exactly one cycle, then return to IDLE.
- `idx` is an IDX_W-bit counter.
  - It never wraps during a dump, because the terminal check happens before the increment.
  - When `NUM_REGS` is smaller than `2**IDX_W`, indices at or above `NUM_REGS` are never produced.
- `start` while busy is ignored; it is not queued.
- `start` and `clr` in the same cycle: `clr` wins, and the block stays in IDLE.
- `clr` mid-dump: the next state is IDLE, and all outputs take their reset values.
  - A word that was valid but not yet accepted is dropped.
  - No `done` pulse is produced.
- Reset values: state IDLE, `idx=0`, `busy=0`, `done=0`, `rd_sel=0`, `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`.
- `out_data`, `out_index` and `out_last` change only at a FETCH capture edge or at reset.

## Timing
- `start` sampled at edge N: FETCH is the cycle after N. `rd_sel` is asserted in that cycle, and `out_valid` is first high one cycle later.
- Per-word cost is 2 cycles with `out_ready` held high: one FETCH cycle and one SEND cycle.
- Full dump with `out_ready=1`: `start` edge, then `2*NUM_REGS` cycles (32 for the default), then the `done` cycle. `busy` is high for `2*NUM_REGS+1` cycles.
- `rd_data` must settle within the FETCH cycle. The block adds no combinational path from `rd_data` to any output.
- `out_valid` never depends combinationally on `out_ready`. There is no same-cycle re-FETCH.

## Structure
- A shared package `dump_pkg` holds:
  - the state enum `{IDLE, FETCH, SEND, DONE}`;
  - the default `NUM_REGS`;
  - the 32-bit data width constant.
- The capture buffer is one instance of the team's 32-bit `register` block:
  - `enable` = (state==FETCH);
  - `clr` = `clr`;
  - `d` = `rd_data`.
- The FSM, `idx` counter, `rd_sel` decode and `out_index`/`out_last` flops stay in the top module.

## Test plan
- **Reset**: assert `clr` for 2 cycles with random inputs. Every output reads 0 and `busy=0`.
- **Basic dump**:
  - Stimulus: register k holds `0xA5A50000+k`, `out_ready=1`, one `start` pulse.
  - Required: 16 words `0xA5A50000..0xA5A5000F` with `out_index 0..15`, each on alternate cycles. `out_last` is high only on index 15. `done` pulses once, 33 cycles after `start`.
- **Backpressure**:
  - Stimulus: hold `out_ready` low for 5 cycles during word 3.
  - Required: `out_data`, `out_index` and `out_valid` stay stable; `rd_sel` stays 0; no word is lost or duplicated.
- **Start while busy**: pulse `start` again at word 7. The stream is unchanged and exactly one `done` pulse occurs.
- **Reset mid-dump**:
  - Stimulus: assert `clr` in SEND of word 9.
  - Required: next cycle `out_valid=0`, `busy=0`, no `done`. A fresh `start` restarts from index 0.
- **One-hot select**:
  - In every FETCH, `rd_sel == 1<<idx`, and it is exactly one-hot.
  - Outside FETCH, `rd_sel == 0`.
  - The same capture is registered with `rd_data` changing every cycle.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared types and constants for the register dump readout engine.
package dump_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_e;
  localparam int NUM_REGS_DEF = 16;
  localparam int DATA_W       = 32;
endpackage

// File: rtl/register.sv
// Generic loadable register: synchronous clear, load on enable.
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)         q <= '0;
    else if (enable) q <= d;
  end
endmodule

// File: rtl/reg_dump_reader.sv
// Walks every register through the shared out-select lines and streams each
// captured value out on a valid/ready port, with index and last-word tags.
module reg_dump_reader
  import dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [NUM_REGS-1:0] rd_sel,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_last
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] out_index_q;
  logic             out_last_q;
  logic             is_last;
  logic             capture_en;

  assign is_last    = (idx_q == IDX_W'(NUM_REGS - 1));
  assign capture_en = (state_q == FETCH);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (capture_en) begin
        out_index_q <= idx_q;
        out_last_q  <= is_last;
      end
    end
  end

  // Terminal check precedes the increment, so idx never wraps mid-dump.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        idx_d   = '0;
      end
      FETCH: state_d = SEND;
      SEND: if (out_ready) begin
        if (is_last) state_d = DONE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    out_valid = (state_q == SEND);
    rd_sel    = '0;
    if (state_q == FETCH) rd_sel[idx_q] = 1'b1;
  end

  assign out_index = out_index_q;
  assign out_last  = out_last_q;

  register #(.W(DATA_W)) u_capture (
    .clk    (clk),
    .clr    (clr),
    .enable (capture_en),
    .d      (rd_data),
    .q      (out_data)
  );
endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader against a word-level dump model.
module tb_reg_dump_reader;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          clr, start, out_ready;
  logic [31:0]   rd_data;
  logic          busy, done, out_valid, out_last;
  logic [N-1:0]  rd_sel;
  logic [31:0]   out_data;
  logic [IW-1:0] out_index;

  logic [31:0] bank [N];
  logic [31:0] mask  = '0;
  logic [31:0] noise = '0;
  bit          scramble = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Register bank model: contents XOR a per-cycle mask when scrambling,
  // and junk on the read bus whenever nothing is selected.
  always @(posedge clk) begin
    noise <= $urandom;
    mask  <= scramble ? $urandom : 32'h0;
  end

  always_comb begin
    rd_data = noise;
    for (int k = 0; k < N; k++) if (rd_sel[k]) rd_data = bank[k] ^ mask;
  end

  reg_dump_reader #(.NUM_REGS(N), .IDX_W(IW)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done),
    .rd_sel(rd_sel), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start     = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      checks++;
      if ({busy, done, out_valid, out_last, rd_sel, out_data, out_index} !== '0)
        $display("FAIL reset: busy=%b done=%b vld=%b last=%b sel=%h data=%h idx=%0d, all required 0",
                 busy, done, out_valid, out_last, rd_sel, out_data, out_index);
      if ({busy, done, out_valid, out_last, rd_sel, out_data, out_index} !== '0) errors++;
    end
    clr = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  // One full dump driven word by word. stall_w/stall_n: hold ready low on a word;
  // restart_w: pulse start during that word; clr_w: clear during that word's SEND.
  task automatic run_dump(input int stall_w, input int stall_n, input int restart_w,
                          input int clr_w, input bit rnd);
    int           edges, stalls, total_stalls;
    logic [31:0]  exp;
    logic [N-1:0] oh;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    edges = 1; total_stalls = 0;
    for (int k = 0; k < N; k++) begin
      oh = '0; oh[k] = 1'b1;
      checks++;
      if (rd_sel !== oh || busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL fetch[%0d]: sel=%h busy=%b vld=%b done=%b, required sel=%h busy=1 vld=0 done=0",
                 k, rd_sel, busy, out_valid, done, oh);
      end
      exp = bank[k] ^ mask;
      tick(); edges++;
      stalls = 0;
      while (1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp || out_index !== IW'(k) ||
            out_last !== (k == N - 1) || rd_sel !== '0 || done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL send[%0d]: vld=%b data=%h idx=%0d last=%b sel=%h done=%b, required vld=1 data=%h idx=%0d last=%b sel=0 done=0",
                   k, out_valid, out_data, out_index, out_last, rd_sel, done, exp, k, (k == N - 1));
        end
        if (k == clr_w) begin
          clr = 1'b1; start = 1'b1;
          tick();
          clr = 1'b0; start = 1'b0;
          checks++;
          if ({busy, done, out_valid, out_last, rd_sel, out_data, out_index} !== '0) begin
            errors++;
            $display("FAIL clr_mid: busy=%b done=%b vld=%b last=%b sel=%h data=%h idx=%0d, all required 0",
                     busy, done, out_valid, out_last, rd_sel, out_data, out_index);
          end
          for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
              errors++;
              $display("FAIL clr_idle: busy=%b done=%b, required 0 0", busy, done);
            end
          end
          return;
        end
        if (k == restart_w && stalls == 0) start = 1'b1;
        if (k == stall_w && stalls < stall_n) out_ready = 1'b0;
        else if (rnd && stalls < 6 && $urandom_range(0, 1) == 0) out_ready = 1'b0;
        else out_ready = 1'b1;
        tick(); edges++;
        start = 1'b0;
        if (out_ready) break;
        stalls++; total_stalls++;
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || rd_sel !== '0) begin
      errors++;
      $display("FAIL done_cycle: done=%b busy=%b vld=%b sel=%h, required 1 1 0 0",
               done, busy, out_valid, rd_sel);
    end
    if (total_stalls == 0) begin
      checks++;
      if (edges !== 2 * N + 1) begin
        errors++;
        $display("FAIL done_latency: edges=%0d required %0d", edges, 2 * N + 1);
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rd_sel !== '0) begin
        errors++;
        $display("FAIL post_idle[%0d]: busy=%b done=%b vld=%b sel=%h, required all 0",
                 c, busy, done, out_valid, rd_sel);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_basic;
    run_dump(-1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure;
    run_dump(3, 5, -1, -1, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_dump(-1, 0, 7, -1, 1'b0);
  endtask

  task automatic test_clr_mid_dump;
    run_dump(-1, 0, -1, 9, 1'b0);
    run_dump(-1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_scrambled_random_ready;
    for (int k = 0; k < N; k++) bank[k] = $urandom;
    scramble = 1'b1;
    tick();
    run_dump(-1, 0, -1, -1, 1'b1);
    run_dump(-1, 0, -1, -1, 1'b1);
    scramble = 1'b0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < N; k++) bank[k] = 32'hA5A5_0000 + k;
    clr = 1'b1; start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_clr_mid_dump();
    test_scrambled_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
